// File: rtl/mips_step_ctrl.sv
// Run/single-step clock-enable controller for the mips core.
// Optional breakpoint stop is built when MIPS_STEP_BREAKPOINT_EN is defined.
module mips_step_ctrl #(
   parameter int DEBOUNCE    = 4,
   parameter int STEP_CYCLES = 1,
   parameter int COUNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               change,
   input  logic               step,
`ifdef MIPS_STEP_BREAKPOINT_EN
   input  logic [31:0]        pc,
   input  logic [31:0]        bp_addr,
   input  logic               bp_valid,
   output logic               bp_hit,
`endif
   output logic               cpu_en,
   output logic               step_mode,
   output logic [COUNT_W-1:0] step_count
);

   typedef enum logic [1:0] {RUN, STEP_IDLE, STEP_PULSE, STEP_WAIT} state_t;

   state_t     state, next_state;
   logic [1:0] change_sync, step_sync;
   logic       change_s, step_s;
   logic       step_db, step_db_q, step_rise;
   logic [7:0] db_cnt;
   logic [7:0] burst, burst_next;
   logic       count_inc;
   logic       go_run;

   assign change_s  = change_sync[1];
   assign step_s    = step_sync[1];
   assign step_rise = step_db & ~step_db_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         change_sync <= '0;
         step_sync   <= '0;
         step_db     <= 1'b0;
         step_db_q   <= 1'b0;
         db_cnt      <= '0;
      end else begin
         change_sync <= {change_sync[0], change};
         step_sync   <= {step_sync[0], step};
         step_db_q   <= step_db;
         // accept a new level after DEBOUNCE consecutive differing samples
         if (step_s == step_db)
            db_cnt <= '0;
         else if (db_cnt == 8'(DEBOUNCE - 1)) begin
            step_db <= step_s;
            db_cnt  <= '0;
         end else
            db_cnt <= db_cnt + 8'd1;
      end
   end

`ifdef MIPS_STEP_BREAKPOINT_EN
   logic change_s_q, change_fall, hit_set;

   assign change_fall = change_s_q & ~change_s;
   // a latched hit pins the FSM in step mode until change toggles 1->0
   assign go_run = ~change_s & (~bp_hit | change_fall);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         change_s_q <= 1'b0;
         bp_hit     <= 1'b0;
      end else begin
         change_s_q <= change_s;
         if (hit_set)
            bp_hit <= 1'b1;
         else if (change_fall)
            bp_hit <= 1'b0;
      end
   end
`else
   assign go_run = ~change_s;
`endif

   always_comb begin
      next_state = state;
      burst_next = burst;
      count_inc  = 1'b0;
`ifdef MIPS_STEP_BREAKPOINT_EN
      hit_set    = 1'b0;
`endif
      case (state)
         RUN: begin
            if (change_s)
               next_state = STEP_IDLE;
`ifdef MIPS_STEP_BREAKPOINT_EN
            else if (cpu_en && bp_valid && (pc == bp_addr)) begin
               next_state = STEP_IDLE;
               hit_set    = 1'b1;
            end
`endif
         end
         STEP_IDLE: begin
            if (go_run)
               next_state = RUN;
            else if (step_rise) begin
               next_state = STEP_PULSE;
               burst_next = 8'(STEP_CYCLES - 1);
            end
         end
         STEP_PULSE: begin
            // a burst always runs to completion, even if change drops
            if (burst == 8'd0) begin
               count_inc  = 1'b1;
               next_state = go_run ? RUN : STEP_WAIT;
            end else
               burst_next = burst - 8'd1;
         end
         STEP_WAIT: begin
            if (go_run)
               next_state = RUN;
            else if (!step_db)
               next_state = STEP_IDLE;
         end
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         burst      <= '0;
         cpu_en     <= 1'b0;
         step_mode  <= 1'b0;
         step_count <= '0;
      end else begin
         state     <= next_state;
         burst     <= burst_next;
         cpu_en    <= (next_state == RUN) || (next_state == STEP_PULSE);
         step_mode <= (next_state != RUN);
         if (count_inc)
            step_count <= step_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Directed bench for mips_step_ctrl: run/step modes, debounce, bursts, async reset
// and, when MIPS_STEP_BREAKPOINT_EN is defined, the breakpoint stop.
module tb_mips_step_ctrl;

   logic        clock, reset;
   logic        change, step, change2, step2;
   logic        cpu_en, step_mode, cpu_en2, step_mode2;
   logic [15:0] step_count, step_count2;
   int          n_cmp, n_err;
   int          highs, first;

`ifdef MIPS_STEP_BREAKPOINT_EN
   logic [31:0] pc, bp_addr;
   logic        bp_valid, bp_hit, bp_hit2, bp_test;
`endif

   mips_step_ctrl #(.DEBOUNCE(4), .STEP_CYCLES(1), .COUNT_W(16)) dut (
      .clock(clock), .reset(reset), .change(change), .step(step),
`ifdef MIPS_STEP_BREAKPOINT_EN
      .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit),
`endif
      .cpu_en(cpu_en), .step_mode(step_mode), .step_count(step_count));

   mips_step_ctrl #(.DEBOUNCE(4), .STEP_CYCLES(5), .COUNT_W(16)) dut5 (
      .clock(clock), .reset(reset), .change(change2), .step(step2),
`ifdef MIPS_STEP_BREAKPOINT_EN
      .pc(32'h0), .bp_addr(32'h0), .bp_valid(1'b0), .bp_hit(bp_hit2),
`endif
      .cpu_en(cpu_en2), .step_mode(step_mode2), .step_count(step_count2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef MIPS_STEP_BREAKPOINT_EN
   // core model: pc advances by 4 on every enabled cycle
   always @(negedge clock) if (bp_test && cpu_en) pc = pc + 32'd4;
`endif

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; change = 1'b0; step = 1'b0; change2 = 1'b0; step2 = 1'b0;
`ifdef MIPS_STEP_BREAKPOINT_EN
      pc = 32'h0; bp_addr = 32'h0; bp_valid = 1'b0; bp_test = 1'b0;
`endif
      // reset state and first enable after release
      tick(2);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_step_mode", step_mode, 0);
      chk("rst_count", step_count, 0);
      reset = 1'b0;
      tick(1);
      chk("run_first_en", cpu_en, 1);
      highs = 0;
      for (int e = 0; e < 10; e++) begin
         tick(1);
         if (cpu_en) highs++;
      end
      chk("run_continuous", highs, 10);
      chk("run_step_mode", step_mode, 0);

      // enter step mode; core holds still with no press
      change = 1'b1;
      tick(4);
      chk("step_entry_en", cpu_en, 0);
      chk("step_entry_mode", step_mode, 1);
      highs = 0;
      for (int e = 0; e < 50; e++) begin
         tick(1);
         if (cpu_en) highs++;
      end
      chk("step_idle_quiet", highs, 0);

      // three held presses -> one pulse each, 7 edges after press
      for (int p = 0; p < 3; p++) begin
         highs = 0; first = 0;
         step = 1'b1;
         for (int e = 1; e <= 40; e++) begin
            tick(1);
            if (cpu_en) begin
               highs++;
               if (first == 0) first = e;
            end
            if (e == 20) step = 1'b0;
         end
         chk("press_pulses", highs, 1);
         chk("press_latency", first, 7);
      end
      chk("press_count", step_count, 3);

      // 3-cycle glitches are shorter than the debounce window
      highs = 0;
      for (int p = 0; p < 3; p++) begin
         step = 1'b1;
         for (int e = 1; e <= 13; e++) begin
            tick(1);
            if (cpu_en) highs++;
            if (e == 3) step = 1'b0;
         end
      end
      chk("glitch_pulses", highs, 0);
      chk("glitch_count", step_count, 3);

      // five-cycle burst with change dropped mid-burst
      change2 = 1'b1;
      tick(10);
      chk("b5_idle_en", cpu_en2, 0);
      highs = 0;
      step2 = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick(1);
         if (e == 6) chk("b5_before", cpu_en2, 0);
         if (e >= 7 && cpu_en2) highs++;
         if (e == 8) change2 = 1'b0;
         if (e == 11) chk("b5_in_burst", step_mode2, 1);
         if (e == 12) chk("b5_to_run", step_mode2, 0);
      end
      step2 = 1'b0;
      chk("b5_high_run", highs, 14);
      chk("b5_count", step_count2, 1);

      // asynchronous reset during a step pulse
      step = 1'b1;
      repeat (7) @(posedge clock);
      #2;
      chk("mid_pulse_en", cpu_en, 1);
      reset = 1'b1;
      #1;
      chk("async_drop_en", cpu_en, 0);
      chk("async_count", step_count, 0);
      step = 1'b0; change = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      tick(1);
      chk("post_rst_en", cpu_en, 1);
      chk("post_rst_mode", step_mode, 0);

`ifdef MIPS_STEP_BREAKPOINT_EN
      bp_addr = 32'h20; bp_valid = 1'b1; pc = 32'h0; bp_test = 1'b1;
      first = 0;
      for (int e = 0; e < 40 && first == 0; e++) begin
         tick(1);
         if (!cpu_en) first = 1;
      end
      chk("bp_stopped", first, 1);
      chk("bp_pc", pc, 32'h20);
      chk("bp_hit_set", bp_hit, 1);
      chk("bp_step_mode", step_mode, 1);
      highs = 0;
      for (int e = 0; e < 10; e++) begin
         tick(1);
         if (cpu_en) highs++;
      end
      chk("bp_hold", highs, 0);
      highs = 0;
      step = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         tick(1);
         if (cpu_en) highs++;
         if (e == 20) step = 1'b0;
      end
      chk("bp_one_step", highs, 1);
      chk("bp_pc_step", pc, 32'h24);
      chk("bp_hit_kept", bp_hit, 1);
      change = 1'b1;
      tick(10);
      change = 1'b0;
      tick(5);
      chk("bp_hit_clr", bp_hit, 0);
      chk("bp_run_en", cpu_en, 1);
      chk("bp_run_mode", step_mode, 0);
      bp_test = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
